// File: rtl/mc_ctrl_fsm_if.sv
// Unified memory port between the multicycle controller and the memory.
// The controller drives the request, address select and store strobe.
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic AdrSrc;
    logic MemWrite;

    modport master (output mem_req, output AdrSrc, output MemWrite, input mem_ready);
    modport slave  (input mem_req, input AdrSrc, input MemWrite, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback over a
// shared ALU, with a memory ready handshake, illegal-opcode trap and retire counter.
module mc_ctrl_fsm #(
    parameter bit USE_READY   = 1'b1,
    parameter bit TRAP_RESUME = 1'b0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_fsm_if.master    mem,
    input  logic [6:0]       opcode,
    input  logic             Btaken,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrc_A,
    output logic [1:0]       ALUSrc_B,
    output logic [1:0]       ALUop,
    output logic [2:0]       ImmSrc,
    output logic             Branch,
    output logic             Csr,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6, EXECI   = 4'd7,
        ALUWB    = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR   = 4'd11,
        LINK     = 4'd12, UPPER  = 4'd13, CSR    = 4'd14, TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    state_t cur, nxt;
    logic   ready;
    logic   req_d, irw_d, pcupd_d, mw_d, rw_d, adr_d;

    assign ready = USE_READY ? mem.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:    if (ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      nxt = MEMADR;
                    OP_R:              nxt = EXECR;
                    OP_I:              nxt = EXECI;
                    OP_B:              nxt = BRANCH;
                    OP_JAL:            nxt = JAL;
                    OP_JALR:           nxt = JALR;
                    OP_LUI, OP_AUIPC:  nxt = UPPER;
                    OP_CSR:            nxt = CSR;
                    default:           nxt = TRAP;
                endcase
            end
            MEMADR:   nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (ready) nxt = MEMWB;
            MEMWB:    nxt = FETCH;
            MEMWRITE: if (ready) nxt = FETCH;
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BRANCH:   nxt = FETCH;
            JAL:      nxt = ALUWB;
            JALR:     nxt = LINK;
            LINK:     nxt = ALUWB;
            UPPER:    nxt = ALUWB;
            CSR:      nxt = FETCH;
            TRAP:     nxt = TRAP_RESUME ? FETCH : TRAP;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        req_d     = 1'b0;
        adr_d     = 1'b0;
        irw_d     = 1'b0;
        pcupd_d   = 1'b0;
        mw_d      = 1'b0;
        rw_d      = 1'b0;
        ResultSrc = 2'b00;
        ALUSrc_A  = 2'b00;
        ALUSrc_B  = 2'b00;
        ALUop     = 2'b00;
        ImmSrc    = 3'b000;
        Branch    = 1'b0;
        Csr       = 1'b0;
        case (cur)
            FETCH: begin
                req_d = 1'b1; ALUSrc_A = 2'b11; ALUSrc_B = 2'b10; ResultSrc = 2'b10;
                irw_d = ready; pcupd_d = ready;
            end
            DECODE: begin
                ALUSrc_A = 2'b01; ALUSrc_B = 2'b01;
                ImmSrc   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            MEMADR: begin
                ALUSrc_B = 2'b01;
                ImmSrc   = (opcode == OP_SW) ? 3'b001 : 3'b000;
            end
            MEMREAD:  begin req_d = 1'b1; adr_d = 1'b1; end
            MEMWB:    begin ResultSrc = 2'b01; rw_d = 1'b1; end
            MEMWRITE: begin req_d = 1'b1; adr_d = 1'b1; mw_d = 1'b1; end
            EXECR:    ALUop = 2'b10;
            EXECI:    begin ALUSrc_B = 2'b01; ALUop = 2'b10; end
            ALUWB:    rw_d = 1'b1;
            BRANCH:   begin ALUop = 2'b01; ImmSrc = 3'b010; Branch = 1'b1; end
            JAL:      begin ALUSrc_A = 2'b01; ALUSrc_B = 2'b10; pcupd_d = 1'b1; end
            JALR:     begin ALUSrc_B = 2'b01; ResultSrc = 2'b10; pcupd_d = 1'b1; end
            LINK:     begin ALUSrc_A = 2'b01; ALUSrc_B = 2'b10; end
            UPPER: begin
                ImmSrc   = 3'b100; ALUSrc_B = 2'b01;
                ALUSrc_A = (opcode == OP_LUI) ? 2'b10 : 2'b01;
            end
            CSR:      begin Csr = 1'b1; ALUSrc_B = 2'b01; rw_d = 1'b1; end
            default:  ;
        endcase
    end

    // Write strobes are suppressed while reset is high, even mid-stall.
    assign mem.mem_req  = req_d & ~reset;
    assign mem.AdrSrc   = adr_d;
    assign mem.MemWrite = mw_d & ~reset;
    assign IRWrite      = irw_d & ~reset;
    assign PCWrite      = (pcupd_d | (Branch & Btaken)) & ~reset;
    assign RegWrite     = rw_d & ~reset;
    assign state        = cur;

    assign instr_done = (nxt == FETCH) && (cur != FETCH) && (cur != TRAP) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (instr_done)   instret <= instret + CNT_W'(1);
            if (nxt == TRAP)  illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each driven cycle pushes its expected
// state/controls, and a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;
    localparam int CW = 2;

    localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3,
                           S_MWB = 4'd4, S_MW = 4'd5, S_ER = 4'd6, S_EI = 4'd7,
                           S_AWB = 4'd8, S_BR = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                           S_LINK = 4'd12, S_UP = 4'd13, S_CSR = 4'd14, S_TRAP = 4'd15;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_CSR = 7'b1110011;

    typedef struct {
        logic [3:0]    st;
        logic [18:0]   ctl;
        logic          done;
        logic [CW-1:0] cnt;
        logic          ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          Btaken = 1'b0;
    logic          IRWrite, PCWrite, RegWrite, Branch, Csr, illegal, instr_done;
    logic [1:0]    ResultSrc, ALUSrc_A, ALUSrc_B, ALUop;
    logic [2:0]    ImmSrc;
    logic [CW-1:0] instret;
    logic [3:0]    state;
    logic [18:0]   ctlVec;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    exp_t          mon;
    logic [CW-1:0] expCnt = '0;
    logic          expIll = 1'b0;
    logic [6:0]    curOp;
    logic          curBt;

    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm #(.USE_READY(1'b1), .TRAP_RESUME(1'b0), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mem(bus.master), .opcode(opcode), .Btaken(Btaken),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALUop(ALUop), .ImmSrc(ImmSrc),
        .Branch(Branch), .Csr(Csr), .illegal(illegal), .instr_done(instr_done),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    assign ctlVec = {bus.mem_req, bus.AdrSrc, IRWrite, PCWrite, bus.MemWrite, RegWrite,
                     ResultSrc, ALUSrc_A, ALUSrc_B, ALUop, ImmSrc, Branch, Csr};

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Control word expected in each state, straight from the state table.
    function automatic logic [18:0] expCtl(logic [3:0] st, logic [6:0] op, logic bt,
                                           logic rdy, logic rst);
        logic       mreq = 0, adr = 0, irw = 0, pcw = 0, mw = 0, rw = 0, br = 0, cs = 0;
        logic [1:0] rs = 0, a = 0, b = 0, alu = 0;
        logic [2:0] imm = 0;
        case (st)
            S_F:    begin mreq = 1; a = 2'b11; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            S_D:    begin a = 2'b01; b = 2'b01; imm = (op == OP_JAL) ? 3'b011 : 3'b010; end
            S_MA:   begin b = 2'b01; imm = (op == OP_SW) ? 3'b001 : 3'b000; end
            S_MR:   begin mreq = 1; adr = 1; end
            S_MWB:  begin rs = 2'b01; rw = 1; end
            S_MW:   begin mreq = 1; adr = 1; mw = 1; end
            S_ER:   alu = 2'b10;
            S_EI:   begin b = 2'b01; alu = 2'b10; end
            S_AWB:  rw = 1;
            S_BR:   begin alu = 2'b01; imm = 3'b010; br = 1; pcw = bt; end
            S_JAL:  begin a = 2'b01; b = 2'b10; pcw = 1; end
            S_JALR: begin b = 2'b01; rs = 2'b10; pcw = 1; end
            S_LINK: begin a = 2'b01; b = 2'b10; end
            S_UP:   begin imm = 3'b100; b = 2'b01; a = (op == OP_LUI) ? 2'b10 : 2'b01; end
            S_CSR:  begin cs = 1; b = 2'b01; rw = 1; end
            default: ;
        endcase
        if (rst) begin mreq = 0; irw = 0; pcw = 0; mw = 0; rw = 0; end
        return {mreq, adr, irw, pcw, mw, rw, rs, a, b, alu, imm, br, cs};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic cycleOut(input logic [3:0] st, input logic rdy, input logic last, input logic rst);
        exp_t e;
        reset         = rst;
        opcode        = curOp;
        bus.mem_ready = rdy;
        Btaken        = (st == S_BR) ? curBt : rb();
        if (st == S_TRAP) expIll = 1'b1;
        e.st   = st;
        e.ctl  = expCtl(st, curOp, Btaken, rdy, rst);
        e.done = last & ~rst;
        e.cnt  = expCnt;
        e.ill  = expIll;
        sb.push_back(e);
        @(posedge clk); #1;
        if (rst) begin
            expCnt = '0;
            expIll = 1'b0;
        end else if (last) begin
            expCnt = expCnt + 1'b1;
        end
    endtask

    // One instruction: fw fetch waits, mw memory waits (or TRAP hold cycles).
    task automatic applyStimulus(input logic [6:0] op, input logic bt, input int fw,
                                 input int mw, input bit abortMem);
        curOp = op;
        curBt = bt;
        repeat (fw) cycleOut(S_F, 1'b0, 1'b0, 1'b0);
        cycleOut(S_F, 1'b1, 1'b0, 1'b0);
        cycleOut(S_D, rb(), 1'b0, 1'b0);
        case (op)
            OP_LW: begin
                cycleOut(S_MA, rb(), 0, 0);
                repeat (mw) cycleOut(S_MR, 1'b0, 0, 0);
                cycleOut(S_MR, 1'b1, 0, 0);
                cycleOut(S_MWB, rb(), 1, 0);
            end
            OP_SW: begin
                cycleOut(S_MA, rb(), 0, 0);
                repeat (mw) cycleOut(S_MW, 1'b0, 0, 0);
                if (abortMem) cycleOut(S_MW, 1'b0, 0, 1);
                else          cycleOut(S_MW, 1'b1, 1, 0);
            end
            OP_R:    begin cycleOut(S_ER, rb(), 0, 0);   cycleOut(S_AWB, rb(), 1, 0); end
            OP_I:    begin cycleOut(S_EI, rb(), 0, 0);   cycleOut(S_AWB, rb(), 1, 0); end
            OP_B:    cycleOut(S_BR, rb(), 1, 0);
            OP_JAL:  begin cycleOut(S_JAL, rb(), 0, 0);  cycleOut(S_AWB, rb(), 1, 0); end
            OP_JALR: begin
                cycleOut(S_JALR, rb(), 0, 0);
                cycleOut(S_LINK, rb(), 0, 0);
                cycleOut(S_AWB, rb(), 1, 0);
            end
            OP_LUI, OP_AUIPC: begin cycleOut(S_UP, rb(), 0, 0); cycleOut(S_AWB, rb(), 1, 0); end
            OP_CSR:  cycleOut(S_CSR, rb(), 1, 0);
            default: repeat (mw) cycleOut(S_TRAP, rb(), 0, 0);
        endcase
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon = sb.pop_front();
            checkOutput("state",      32'(state),      32'(mon.st));
            checkOutput("controls",   32'(ctlVec),     32'(mon.ctl));
            checkOutput("instr_done", 32'(instr_done), 32'(mon.done));
            checkOutput("instret",    32'(instret),    32'(mon.cnt));
            checkOutput("illegal",    32'(illegal),    32'(mon.ill));
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [6:0] legal [10];
        legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_CSR};
        curOp = OP_R;
        curBt = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        cycleOut(S_F, rb(), 0, 1);
        cycleOut(S_F, rb(), 0, 1);

        applyStimulus(OP_LW, 0, 2, 1, 0);
        applyStimulus(OP_R, 0, 0, 0, 0);
        applyStimulus(OP_I, 0, 0, 0, 0);
        applyStimulus(OP_B, 1, 0, 0, 0);
        applyStimulus(OP_B, 0, 0, 0, 0);
        applyStimulus(OP_SW, 0, 1, 2, 0);
        applyStimulus(OP_JAL, 0, 0, 0, 0);
        applyStimulus(OP_JALR, 0, 0, 0, 0);
        applyStimulus(OP_LUI, 0, 0, 0, 0);
        applyStimulus(OP_AUIPC, 0, 0, 0, 0);

        applyStimulus(7'b0000000, 0, 0, 10, 0);
        cycleOut(S_TRAP, rb(), 0, 1);

        applyStimulus(OP_SW, 0, 0, 2, 1);

        curOp = OP_CSR;
        cycleOut(S_F, rb(), 0, 1);
        repeat (5) applyStimulus(OP_CSR, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++)
            applyStimulus(legal[$urandom_range(0, 9)], rb(), $urandom_range(0, 2),
                          $urandom_range(0, 2), 0);

        @(negedge clk); #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
